// File: rtl/mult8b_pkg.sv
// Shared widths, operand/result types and handshake state encoding for the
// 8x8 unsigned array multiplier.
package mult8b_pkg;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [RES_W-1:0] res_t;

  // Single state bit behind the registered completion flag.
  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used for every carry-save and ripple position of
// the array multiplier; a half adder is this cell with cin tied to 0.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/multiplier_8b.sv
// Unsigned 8x8 -> 16-bit combinational array multiplier with a registered
// one-cycle start/done handshake.
// Optional build macro MULT8B_ASSERT_EN adds simulation-only self checks
// (product correctness and done-low after reset release); the datapath and
// the done flop are identical either way.
module multiplier_8b
  import mult8b_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  output logic             done,
  output logic [RES_W-1:0] result
);

  // Partial products: row i holds A gated by bit i of B (weight i+j for bit j).
  op_t pp [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = A & {OP_W{B[i]}};
  end

  // Carry-save array. Row 0 is the raw first partial product; each of the
  // following seven rows adds the next partial product to the previous
  // row's shifted sums and unshifted carries. sum[j] of row k has weight
  // k+j, carry[j] of row k has weight k+j+1, and sum[0] of each row is a
  // finished low product bit.
  for (genvar k = 0; k < OP_W; k++) begin : g_row
    op_t sum;
    op_t carry;

    if (k == 0) begin : g_first
      assign sum   = pp[0];
      assign carry = '0;
    end else begin : g_csa
      for (genvar j = 0; j < OP_W; j++) begin : g_cell
        logic b_in;

        // The leftmost cell of each row has no shifted sum feeding it.
        if (j < OP_W - 1) begin : g_mid
          assign b_in = g_row[k-1].sum[j+1];
        end else begin : g_edge
          assign b_in = 1'b0;
        end

        full_adder u_fa (
          .a   (pp[k][j]),
          .b   (b_in),
          .cin (g_row[k-1].carry[j]),
          .s   (sum[j]),
          .cout(carry[j])
        );
      end
    end

    assign result[k] = sum[0];
  end

  // Final ripple-carry row merges the last row's sums and carries into the
  // upper eight product bits. The top column only ever has two inputs, and
  // the full product always fits in 16 bits, so it can never carry out and
  // closes with a plain XOR.
  for (genvar j = 0; j < OP_W; j++) begin : g_rip
    logic cin;

    if (j == 0) begin : g_cin0
      assign cin = 1'b0;
    end else begin : g_cinn
      assign cin = g_rip[j-1].g_fa.co;
    end

    if (j < OP_W - 1) begin : g_fa
      logic co;

      full_adder u_fa (
        .a   (g_row[OP_W-1].sum[j+1]),
        .b   (g_row[OP_W-1].carry[j]),
        .cin (cin),
        .s   (result[OP_W+j]),
        .cout(co)
      );
    end else begin : g_top
      assign result[RES_W-1] = g_row[OP_W-1].carry[j] ^ cin;
    end
  end

  // Handshake state register: cleared asynchronously by reset.
  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state simply follows the sampled start strobe.
  always_comb begin
    next_state = IDLE;
    if (start) begin
      next_state = DONE;
    end
  end

  assign done = (state == DONE);

`ifdef MULT8B_ASSERT_EN
  // Tracks whether at least one clocked edge has passed since reset release.
  logic out_of_reset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
    end
  end

  // Product must match a behavioural multiply whenever operands are known.
  always_comb begin
    if (!$isunknown({A, B})) begin
      assert (result == res_t'(res_t'(A) * res_t'(B)))
        else $error("multiplier_8b: result %h != %h * %h", result, A, B);
    end
  end

  // done must still be low in the first cycle after reset deassertion.
  always @(posedge clk) begin
    if (rst_n && !out_of_reset) begin
      assert (done == 1'b0)
        else $error("multiplier_8b: done high in first cycle after reset");
    end
  end
`endif

endmodule

// File: tb/tb_multiplier_8b.sv
// Self-checking bench for multiplier_8b: exhaustive combinational product,
// directed corners, reset and handshake behaviour, plus randomized cycles
// against a plain-arithmetic reference model.
module tb_multiplier_8b;
  import mult8b_pkg::*;

  logic       clk;
  logic       clkEn;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       done;
  logic [15:0] result;

  int checks;
  int failures;
  logic expDone;

  multiplier_8b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .done  (done),
    .result(result)
  );

  // Free-running clock that can be parked low for the combinational sweep.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clkEn) clk = ~clk;
      else clk = 1'b0;
    end
  end

  task automatic checkValue(input string tag, input logic [15:0] observed,
                            input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%04h expected=0x%04h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'(x) * int'(y);
    return p[15:0];
  endfunction

  // Drive inputs just after a falling edge, let one rising edge sample them,
  // and return at the next falling edge ready to check.
  task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b);
    start = s;
    A     = a;
    B     = b;
    @(posedge clk);
    expDone = rst_n ? s : 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_done"}, {15'd0, done}, {15'd0, expDone});
    checkValue({tag, "_result"}, result, refProduct(A, B));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clkEn    = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    A        = 8'd0;
    B        = 8'd0;
    expDone  = 1'b0;

    // Reset state and product valid while reset is held.
    #1;
    checkValue("reset_done", {15'd0, done}, 16'd0);
    A = 8'd12; B = 8'd11; #1;
    checkValue("reset_result", result, 16'd132);

    // Directed corners with the clock stopped.
    rst_n = 1'b1;
    A = 8'd255; B = 8'd255; #1; checkValue("corner_255x255", result, 16'hFE01);
    A = 8'd0;   B = 8'd200; #1; checkValue("corner_0x200",   result, 16'd0);
    A = 8'd1;   B = 8'd173; #1; checkValue("corner_1x173",   result, 16'd173);
    A = 8'd128; B = 8'd2;   #1; checkValue("corner_128x2",   result, 16'd256);
    A = 8'd16;  B = 8'd16;  #1; checkValue("corner_16x16",   result, 16'd256);

    // Exhaustive sweep, clock parked low, no start.
    $display("[TB] exhaustive product sweep");
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        A = a[7:0];
        B = b[7:0];
        #1;
        checkValue("exhaustive", result, refProduct(A, B));
      end
    end

    // start held during reset must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    clkEn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkValue("start_in_reset", {15'd0, done}, 16'd0);
    rst_n   = 1'b1;
    start   = 1'b0;
    expDone = 1'b0;

    // First edge after release samples start normally.
    applyStimulus(1'b0, 8'd9, 8'd9);  checkOutput("post_reset_idle");

    // Single pulse gives exactly one cycle of done.
    applyStimulus(1'b1, 8'd20, 8'd30); checkOutput("pulse_high");
    applyStimulus(1'b0, 8'd20, 8'd30); checkOutput("pulse_low");

    // start held three cycles gives three cycles of done.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(i + 1), 8'd100);
      checkOutput("hold_high");
    end
    applyStimulus(1'b0, 8'd5, 8'd6); checkOutput("hold_release");

    // Asynchronous reset pulse mid-operation.
    applyStimulus(1'b1, 8'd44, 8'd3); checkOutput("midreset_before");
    start = 1'b0;
    #1 rst_n = 1'b0;
    expDone = 1'b0;
    #1;
    checkValue("midreset_async", {15'd0, done}, 16'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd44, 8'd3); checkOutput("midreset_stay");
    applyStimulus(1'b1, 8'd44, 8'd3); checkOutput("midreset_restart");

    // Operand change while done is high, no clock edge in between.
    applyStimulus(1'b1, 8'd3, 8'd5); checkOutput("opchange_first");
    checkValue("opchange_15", result, 16'd15);
    A = 8'd7;
    #1;
    checkValue("opchange_35", result, 16'd35);
    checkValue("opchange_done", {15'd0, done}, 16'd1);

    // Randomized handshake and operands against the reference model.
    $display("[TB] randomized cycles");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      checkOutput("random");
    end

    clkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
